// File: rtl/seq_shift_register.sv
// rtl/seq_shift_register.sv - accumulator/shift unit with serial multi-bit shifts and start/busy/done handshake
module seq_shift_register #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [3:0]             op,
  input  logic [SHAMT_WIDTH-1:0] amt,
  input  logic [DATA_WIDTH-1:0]  in,
  input  logic                   ir,
  input  logic                   il,
  output logic [DATA_WIDTH-1:0]  out,
  output logic                   busy,
  output logic                   done,
  output logic                   zero,
  output logic                   neg,
  output logic                   carry
);

  localparam logic [3:0] OP_CLR = 4'd1;
  localparam logic [3:0] OP_LD  = 4'd2;
  localparam logic [3:0] OP_INC = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SAR = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [3:0]             op_q;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]  step_out;
  logic                   step_carry;
  logic                   is_shift;

  assign zero     = (out == '0);
  assign neg      = out[DATA_WIDTH-1];
  assign is_shift = (op >= OP_SHL) && (op <= OP_ROR);

  // One-bit step of the latched shift op; fills are sampled live on each edge.
  always_comb begin
    step_out   = out;
    step_carry = 1'b0;
    case (op_q)
      OP_SHL: begin step_out = {out[DATA_WIDTH-2:0], il};              step_carry = out[DATA_WIDTH-1]; end
      OP_SHR: begin step_out = {ir, out[DATA_WIDTH-1:1]};              step_carry = out[0];            end
      OP_SAR: begin step_out = {out[DATA_WIDTH-1], out[DATA_WIDTH-1:1]}; step_carry = out[0];          end
      OP_ROL: begin step_out = {out[DATA_WIDTH-2:0], out[DATA_WIDTH-1]}; step_carry = out[DATA_WIDTH-1]; end
      OP_ROR: begin step_out = {out[0], out[DATA_WIDTH-1:1]};          step_carry = out[0];            end
      default: begin step_out = out; step_carry = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      cnt   <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      carry <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_shift && amt != '0) begin
              state <= SHIFT;
              op_q  <= op;
              cnt   <= amt;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
              case (op)
                OP_CLR: begin out <= '0; carry <= 1'b0; end
                OP_LD:  begin out <= in; carry <= 1'b0; end
                OP_INC: begin out <= out + 1'b1; carry <= &out; end
                OP_DEC: begin out <= out - 1'b1; carry <= (out == '0); end
                OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: carry <= 1'b0;
                default: ;
              endcase
            end
          end
        end
        SHIFT: begin
          out   <= step_out;
          carry <= step_carry;
          cnt   <= cnt - 1'b1;
          if (cnt == SHAMT_WIDTH'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_register.sv
// tb/tb_seq_shift_register.sv - directed plus randomized bench for seq_shift_register against an arithmetic model
module tb_seq_shift_register;
  localparam int W  = 8;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    op = '0;
  logic [SW-1:0] amt = '0;
  logic [W-1:0]  din = '0;
  logic          ir = 1'b0;
  logic          il = 1'b0;
  logic [W-1:0]  dout;
  logic          busy, done, zero, neg, carry;

  int checks = 0;
  int errors = 0;
  int m_out = 0;
  int m_carry = 0;
  int fill_mode = -1;
  int spur_mode = 0;
  bit saw_done;

  always #5 clk = ~clk;

  seq_shift_register #(.DATA_WIDTH(W), .SHAMT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amt(amt), .in(din),
    .ir(ir), .il(il), .out(dout), .busy(busy), .done(done), .zero(zero),
    .neg(neg), .carry(carry)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(string tag, bit exp_busy, bit exp_done);
    check({tag, ".out"},   32'(dout),  m_out);
    check({tag, ".carry"}, 32'(carry), m_carry);
    check({tag, ".zero"},  32'(zero),  (m_out == 0) ? 1 : 0);
    check({tag, ".neg"},   32'(neg),   (m_out >= 128) ? 1 : 0);
    check({tag, ".busy"},  32'(busy),  32'(exp_busy));
    check({tag, ".done"},  32'(done),  32'(exp_done));
  endtask

  // Each shift moves one bit; carry is the bit that falls off the register.
  task automatic model_step(int o, int fl, int fr);
    case (o)
      5: begin m_carry = m_out / 128; m_out = (m_out * 2) % 256 + fl; end
      6: begin m_carry = m_out % 2;   m_out = m_out / 2 + fr * 128; end
      7: begin m_carry = m_out % 2;   m_out = m_out / 2 + ((m_out >= 128) ? 128 : 0); end
      8: begin m_carry = m_out / 128; m_out = (m_out * 2) % 256 + m_out / 128; end
      9: begin m_carry = m_out % 2;   m_out = m_out / 2 + (m_out % 2) * 128; end
      default: ;
    endcase
  endtask

  task automatic idle_cycle();
    @(posedge clk); @(negedge clk);
    check_status("idle", 1'b0, 1'b0);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(int o, int a, int d);
    string tag;
    int fl, fr;
    tag = $sformatf("op%0d_amt%0d", o, a);
    start = 1'b1; op = o[3:0]; amt = a[SW-1:0]; din = d[W-1:0];
    case (o)
      1: begin m_out = 0; m_carry = 0; end
      2: begin m_out = d % 256; m_carry = 0; end
      3: begin m_carry = (m_out == 255) ? 1 : 0; m_out = (m_out + 1) % 256; end
      4: begin m_carry = (m_out == 0) ? 1 : 0;   m_out = (m_out + 255) % 256; end
      5, 6, 7, 8, 9: if (a == 0) m_carry = 0;
      default: ;
    endcase
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    if (o >= 5 && o <= 9 && a > 0) begin
      check_status({tag, ".accept"}, 1'b1, 1'b0);
      for (int i = 1; i <= a; i++) begin
        fl = (fill_mode < 0) ? $urandom_range(0, 1) : fill_mode;
        fr = (fill_mode < 0) ? $urandom_range(0, 1) : fill_mode;
        il = fl[0]; ir = fr[0];
        if (spur_mode == 1 || (spur_mode == 2 && $urandom_range(0, 3) == 0)) begin
          start = 1'b1; op = 4'd2; din = 8'($urandom_range(0, 255));
        end
        model_step(o, fl, fr);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check_status({tag, ".step"}, i != a, i == a);
      end
    end else begin
      check_status({tag, ".single"}, 1'b0, 1'b1);
    end
  endtask

  initial begin
    int o, a, d;
    repeat (2) @(negedge clk);
    check_status("in_reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    idle_cycle();

    run_op(2, 0, 8'hA5);
    check("ld_a5.const", 32'(dout), 32'hA5);
    check("ld_a5.neg", 32'(neg), 1);
    idle_cycle();

    run_op(2, 0, 8'hFF);
    run_op(3, 0, 0);
    check("inc_wrap.const", 32'({carry, zero, dout}), 32'h300);
    run_op(4, 0, 0);
    check("dec_borrow.const", 32'({carry, neg, dout}), 32'h3FF);
    run_op(4, 0, 0);
    check("dec_fe.const", 32'({carry, dout}), 32'h0FE);
    idle_cycle();

    run_op(2, 0, 8'h81);
    fill_mode = 1;
    run_op(5, 3, 0);
    fill_mode = -1;
    check("shl3.const", 32'({carry, dout}), 32'h00F);
    idle_cycle();

    run_op(2, 0, 8'h90);
    run_op(7, 2, 0);
    check("sar2.const", 32'({carry, dout}), 32'h0E4);
    run_op(2, 0, 8'h01);
    run_op(9, 1, 0);
    check("ror1.const", 32'({carry, dout}), 32'h180);
    run_op(2, 0, 8'h5A);
    run_op(8, 8, 0);
    check("rol8.const", 32'(dout), 32'h5A);

    run_op(2, 0, 8'hC3);
    spur_mode = 1;
    run_op(6, 5, 0);
    spur_mode = 0;
    run_op(5, 0, 0);
    check("shl0.const", 32'(carry), 0);
    idle_cycle();

    spur_mode = 2;
    for (int n = 0; n < 40; n++) begin
      o = $urandom_range(0, 15);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9);
      d = $urandom_range(0, 255);
      run_op(o, a, d);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    spur_mode = 0;

    run_op(2, 0, 8'hFF);
    start = 1'b1; op = 4'd9; amt = 5'd20;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.out", 32'(dout), 0);
    check("rst_mid.flags", 32'({busy, done, carry}), 0);
    m_out = 0; m_carry = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("rst_mid.no_done", 32'(saw_done), 0);
    check_status("after_rst", 1'b0, 1'b0);
    run_op(3, 0, 0);
    check("inc_after_rst.const", 32'(dout), 32'h01);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_shift_register.md
Name: seq_shift_register

Overview:
- Parametrised successor to the single-cycle datapath register.
- Adds multi-bit logical, arithmetic and rotate shifts, executed serially one bit per clock.
- Uses a start/busy/done handshake and exposes zero, negative and carry status flags.
- Sits in the datapath as an accumulator/shift unit driven by the control FSM.

Parameters:
- DATA_WIDTH, 16, register width in bits (>= 2).
- SHAMT_WIDTH, 5, width of the shift-amount input; amounts up to 2^SHAMT_WIDTH-1 are allowed, including amounts >= DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation request; sampled only when busy=0.
- op  in  4  opcode: 0 NOP, 1 CLR, 2 LD, 3 INC, 4 DEC, 5 SHL, 6 SHR, 7 SAR, 8 ROL, 9 ROR; codes 10-15 act as NOP.
- amt  in  SHAMT_WIDTH  shift/rotate amount; latched at accept.
- in  in  DATA_WIDTH  load data for LD.
- ir  in  1  serial fill bit for SHR, sampled on every shift edge.
- il  in  1  serial fill bit for SHL, sampled on every shift edge.
- out  out  DATA_WIDTH  register contents.
- busy  out  1  shift in progress.
- done  out  1  one-cycle completion pulse.
- zero  out  1  out == 0 (combinational).
- neg  out  1  out[DATA_WIDTH-1] (combinational).
- carry  out  1  registered status of the last operation.

Behaviour:
- Reset (async, rst_n=0): out=0, busy=0, done=0, carry=0, shift counter=0, FSM=IDLE. Consequently zero=1, neg=0.
- Reset mid-shift aborts the operation; no done pulse is produced.
- FSM has two states: IDLE and SHIFT.
- Accept: start=1 and busy=0 at rising edge E0. op and amt are latched at E0.
- While busy=1, start is ignored; it is neither queued nor flagged.
- done defaults to 0 every cycle, except the cycle after a completion edge.
- A new start may be issued in the same cycle that done=1.
- Single-cycle ops complete at E0; busy stays 0 and done=1 during the cycle after E0:
  - CLR: out=0, carry=0.
  - LD: out=in, carry=0.
  - INC: out=out+1 modulo 2^DATA_WIDTH; carry=1 iff old out was all ones.
  - DEC: out=out-1 modulo 2^DATA_WIDTH; carry=1 iff old out was 0 (borrow).
- NOP or undefined op accepted: out and carry unchanged; done pulses after E0.
- Shift op with amt=0: out unchanged, carry=0, done after E0, busy stays 0.
- Shift op with amt=k>0: IDLE->SHIFT at E0; counter=k, busy=1, out unchanged at E0.
- On each edge E1..Ek, one 1-bit step is applied and the counter decrements:
  - SHL: out={out[W-2:0], il}; carry=old out[W-1].
  - SHR: out={ir, out[W-1:1]}; carry=old out[0].
  - SAR: out={out[W-1], out[W-1:1]}; carry=old out[0].
  - ROL: out={out[W-2:0], out[W-1]}; carry=old out[W-1].
  - ROR: out={out[0], out[W-1:1]}; carry=old out[0].
- At Ek (counter reaches 0): SHIFT->IDLE, busy=0, done=1 for the next cycle.
- Shift timing: busy is high for exactly k cycles; done follows Ek; total latency from E0 is k+1 edges to the done cycle.
- Amounts >= DATA_WIDTH are executed fully, one bit per cycle:
  - Logical shifts end as all fill bits.
  - SAR ends as all sign bits.
  - ROL/ROR by DATA_WIDTH restore the original value.
- carry holds its value until the next accepted operation changes it.
- No arithmetic on amt beyond the down-counter; the counter never wraps below 0.

Test Plan (DATA_WIDTH=8, SHAMT_WIDTH=5):
- Reset release -> out=0x00, zero=1, neg=0, carry=0, busy=0, done=0. LD 0xA5 -> out=0xA5, neg=1, one done pulse.
- LD 0xFF, INC -> out=0x00, carry=1, zero=1. Then DEC -> out=0xFF, carry=1, neg=1. Then DEC -> out=0xFE, carry=0.
- LD 0x81, SHL amt=3, il=1 -> busy high exactly 3 cycles, out steps 0x03, 0x07, 0x0F; final carry=0; done 1 cycle after the last step.
- LD 0x90, SAR amt=2 -> out=0xE4, carry=0. Then ROR amt=1 on 0x01 -> out=0x80, carry=1. Then ROL amt=8 on 0x5A -> out=0x5A after 8 busy cycles.
- SHR amt=5 with start re-pulsed (LD 0x00) during busy -> LD ignored, shift completes normally. SHL amt=0 -> out unchanged, carry=0, done the next cycle, busy never 1. Back-to-back start in the done cycle accepted.
- LD 0xFF, ROR amt=20, assert rst_n=0 mid-shift -> out=0x00, busy=0, done=0, carry=0 immediately, no later done. After release, INC -> out=0x01.
